wb_byte_master: RTL and testbench



---
 rtl/wb_byte_master.sv | 206 ++++++++++++++++++++
 tb/tb_wb_byte_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_master.sv
// rtl/wb_byte_master.sv - byte-stream command parser driving single classic Wishbone cycles
// Optional bus-cycle abort: define WB_BYTE_MASTER_TIMEOUT_EN.
module wb_byte_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_byte_master: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t      r_state;
  logic        r_is_write;
  logic [1:0]  r_idx;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_resp;
  logic [1:0]  r_resp_left;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [31:0] r_wb_adr;
  logic [31:0] r_wb_dat;
  logic [3:0]  r_wb_sel;
  logic        r_wb_we;
  logic        r_wb_cyc;
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo;
`endif

  logic        w_last_idx;
  logic [31:0] w_addr_next;
  logic [31:0] w_wdata_next;

  assign w_last_idx   = (r_idx == 2'd3);
  assign w_addr_next  = {r_addr[23:0], rx_data};
  assign w_wdata_next = {r_wdata[23:0], rx_data};

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign wb_adr_o = r_wb_adr;
  assign wb_dat_o = r_wb_dat;
  assign wb_sel_o = r_wb_sel;
  assign wb_we_o  = r_wb_we;
  assign wb_cyc_o = r_wb_cyc;
  assign wb_stb_o = r_wb_cyc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_is_write  <= 1'b0;
      r_idx       <= 2'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_resp      <= 32'd0;
      r_resp_left <= 2'd0;
      r_tx_data   <= 8'd0;
      r_tx_valid  <= 1'b0;
      r_wb_adr    <= 32'd0;
      r_wb_dat    <= 32'd0;
      r_wb_sel    <= 4'd0;
      r_wb_we     <= 1'b0;
      r_wb_cyc    <= 1'b0;
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
      r_tmo       <= 16'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_idx <= 2'd0;
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              r_is_write <= (rx_data == CMD_WR);
              r_state    <= S_ADDR;
            end else begin
              r_tx_data   <= RSP_NAK;
              r_tx_valid  <= 1'b1;
              r_resp_left <= 2'd0;
              r_state     <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            r_idx <= r_idx + 2'd1;
            if (!w_last_idx) begin
              r_addr <= w_addr_next;
            end else begin
              r_addr <= {w_addr_next[31:2], 2'b00};
              if (r_is_write) begin
                r_state <= S_DATA;
              end else begin
                // Reads launch straight from the last address byte.
                r_wb_adr <= {w_addr_next[31:2], 2'b00};
                r_wb_dat <= 32'd0;
                r_wb_we  <= 1'b0;
                r_wb_sel <= 4'hF;
                r_wb_cyc <= 1'b1;
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
                r_tmo    <= 16'd0;
`endif
                r_state  <= S_BUS;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            r_idx   <= r_idx + 2'd1;
            r_wdata <= w_wdata_next;
            if (w_last_idx) begin
              r_wb_adr <= r_addr;
              r_wb_dat <= w_wdata_next;
              r_wb_we  <= 1'b1;
              r_wb_sel <= 4'hF;
              r_wb_cyc <= 1'b1;
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
              r_tmo    <= 16'd0;
`endif
              r_state  <= S_BUS;
            end
          end
        end

        S_BUS: begin
          if (wb_ack_i) begin
            r_wb_cyc   <= 1'b0;
            r_wb_sel   <= 4'd0;
            r_wb_we    <= 1'b0;
            r_tx_valid <= 1'b1;
            r_state    <= S_RESP;
            if (r_is_write) begin
              r_tx_data   <= RSP_ACK;
              r_resp_left <= 2'd0;
            end else begin
              r_resp      <= wb_dat_i;
              r_tx_data   <= wb_dat_i[31:24];
              r_resp_left <= 2'd3;
            end
          end
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
          // Ack has priority; abort only once the full budget has elapsed.
          else if (r_tmo == TMO_LAST) begin
            r_wb_cyc    <= 1'b0;
            r_wb_sel    <= 4'd0;
            r_wb_we     <= 1'b0;
            r_tx_data   <= RSP_NAK;
            r_tx_valid  <= 1'b1;
            r_resp_left <= 2'd0;
            r_state     <= S_RESP;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
`endif
        end

        S_RESP: begin
          if (tx_ready) begin
            if (r_resp_left == 2'd0) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'd0;
              r_state    <= S_IDLE;
            end else begin
              r_tx_data   <= r_resp[23:16];
              r_resp      <= {r_resp[23:0], 8'd0};
              r_resp_left <= r_resp_left - 2'd1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_byte_master.sv
// tb/tb_wb_byte_master.sv - directed self-checking bench for wb_byte_master
module tb_wb_byte_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'd0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          cyc_total = 0;
  int          base;
  int          s_cnt = 0;
  int          ack_lat = 2;
  logic        ack_en = 1'b1;
  logic [31:0] slave_rdata = 32'd0;

  wb_byte_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wb_cyc_o) cyc_total = cyc_total + 1;

  // Slave: ack is sampled ack_lat+1 edges after the cycle starts.
  always @(posedge clk) begin
    #1;
    if (wb_cyc_o && ack_en && !wb_ack_i) begin
      s_cnt = s_cnt + 1;
      if (s_cnt == ack_lat + 1) begin
        wb_ack_i = 1'b1;
        wb_dat_i = slave_rdata;
      end
    end else begin
      wb_ack_i = 1'b0;
      s_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_cyc_low(input string tag);
    int n = 0;
    while (wb_cyc_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_cyc_end"}, 32'(wb_cyc_o), 32'd0);
  endtask

  task automatic get_byte(input string tag, input int stall, input logic [7:0] exp);
    int n = 0;
    @(negedge clk);
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(exp));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp});
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_outputs",
        32'({tx_valid, tx_data, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'd0);
    chk("reset_bus", wb_adr_o | wb_dat_o, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Write, ack latency 2
    ack_lat = 2;
    base = cyc_total;
    send_byte(8'h57); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hA5);
    chk("wr_adr", wb_adr_o, 32'h4000_0000);
    chk("wr_dat", wb_dat_o, 32'h0000_00A5);
    chk("wr_ctl", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'h7F);
    wait_cyc_low("wr");
    chk("wr_tx_after_ack", 32'(tx_valid), 32'd1);
    chk("wr_cyc_len", cyc_total - base, 3);
    get_byte("wr_rsp", 0, 8'h06);

    // Read with 3-cycle tx stalls
    ack_lat = 1;
    slave_rdata = 32'hDEAD_BEEF;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h10);
    chk("rd_adr", wb_adr_o, 32'h0000_0010);
    chk("rd_ctl", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'h6F);
    get_byte("rd_b3", 3, 8'hDE);
    get_byte("rd_b2", 3, 8'hAD);
    get_byte("rd_b1", 3, 8'hBE);
    get_byte("rd_b0", 3, 8'hEF);

    // Bad command, then unaligned read address
    base = cyc_total;
    send_byte(8'h41);
    get_byte("bad_rsp", 0, 8'h15);
    chk("bad_no_cyc", cyc_total - base, 0);
    slave_rdata = 32'h1234_5678;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h13);
    chk("align_adr", wb_adr_o, 32'h0000_0010);
    get_byte("al_b3", 0, 8'h12);
    get_byte("al_b2", 0, 8'h34);
    get_byte("al_b1", 0, 8'h56);
    get_byte("al_b0", 0, 8'h78);

    // Busy drop: bytes during response and in the final acceptance cycle
    slave_rdata = 32'hCAFE_F00D;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h20);
    wait_cyc_low("busy");
    send_byte(8'h52);
    get_byte("busy_b3", 0, 8'hCA);
    get_byte("busy_b2", 0, 8'hFE);
    get_byte("busy_b1", 0, 8'hF0);
    @(negedge clk);
    chk("busy_b0", 32'({tx_valid, tx_data}), 32'h10D);
    tx_ready = 1'b1;
    rx_data = 8'h52;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    chk("busy_tx_done", 32'(tx_valid), 32'd0);
    base = cyc_total;
    send_byte(8'h41);
    get_byte("busy_next", 0, 8'h15);
    repeat (3) @(negedge clk);
    chk("busy_no_cyc", cyc_total - base, 0);

    // Timeout: read with no ack
    ack_en = 1'b0;
    base = cyc_total;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h30);
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
    wait_cyc_low("tmo");
    chk("tmo_cyc_len", cyc_total - base, 16);
    get_byte("tmo_rsp", 0, 8'h15);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h30);
`else
    repeat (40) @(negedge clk);
    chk("tmo_cyc_held", 32'(wb_cyc_o), 32'd1);
`endif

    // Asynchronous reset while a cycle is open
    chk("rst_pre_cyc", 32'(wb_cyc_o), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("rst_async_ctl",
        32'({tx_valid, tx_data, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'd0);
    chk("rst_async_bus", wb_adr_o | wb_dat_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ack_en = 1'b1;
    ack_lat = 0;
    base = cyc_total;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h08); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44);
    chk("post_rst_adr", wb_adr_o, 32'h0000_0008);
    chk("post_rst_dat", wb_dat_o, 32'h1122_3344);
    wait_cyc_low("post_rst");
    chk("post_rst_cyc_len", cyc_total - base, 1);
    get_byte("post_rst_rsp", 0, 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
